// File: rtl/aes_cipher_rounds_if.sv
// aes_cipher_rounds_if: input/output valid-ready bundle for the iterative AES-128 cipher
// Ports (signals): in_valid, in_ready, plaintext[0:127], keys[0:KEY_BITS-1],
//                  out_valid, out_ready, ciphertext[0:127], busy
// master = job source and ciphertext sink, slave = cipher core
interface aes_cipher_rounds_if #(
   parameter int KEY_BITS = 1408
);
   logic                in_valid;
   logic                in_ready;
   logic [0:127]        plaintext;
   logic [0:KEY_BITS-1] keys;
   logic                out_valid;
   logic                out_ready;
   logic [0:127]        ciphertext;
   logic                busy;
   modport master (
      output in_valid, plaintext, keys, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );
   modport slave (
      input  in_valid, plaintext, keys, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );
endinterface

// File: rtl/aes_cipher_rounds.sv
// aes_cipher_rounds: iterative AES-128 encryption, one round per clock, valid/ready on both sides
// Ports: clk; reset (async, active-high); bus (slave modport): in_valid/in_ready/plaintext/keys
//        accept a job, out_valid/out_ready/ciphertext return it, busy is high in ROUND or DONE.
// AES_OUT_REG_EN: ciphertext comes from a dedicated register (latency 11, reads 0 while
//        out_valid=0); undefined, ciphertext is the working state (latency 10).
// keys are not latched; the source holds them stable from accept until out_valid.
module aes_cipher_rounds #(
   parameter int NR       = 10,
   parameter int KEY_BITS = (NR + 1) * 128
) (
   input logic                clk,
   input logic                reset,
   aes_cipher_rounds_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, p;
      r = 8'h00;
      p = a;
      for (int i = 0; i < 8; i++) begin
         r = b[i] ? r ^ p : r;
         p = xt(p);
      end
      return r;
   endfunction
   // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r, p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction
   logic [1:0]          state_q, state_d;
   logic [3:0]          round_q, round_d;
   logic [0:127]        st_q, st_d, rnd, rk;
   logic [7:0]          sb [16];
   logic [7:0]          sr [16];
   logic [7:0]          mc [16];
   logic [0:KEY_BITS-1] keys;
   logic                out_valid, handoff;
   assign keys = bus.keys;
   // byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r columns
   always_comb begin
      rk = keys[128 * round_q +: 128];
      for (int i = 0; i < 16; i++) sb[i] = sbox(st_q[8 * i +: 8]);
      for (int i = 0; i < 16; i++) sr[i] = sb[(i % 4) + 4 * ((i / 4 + i % 4) % 4)];
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++) rnd[8 * i +: 8] = (round_q == 4'(NR) ? sr[i] : mc[i]) ^ rk[8 * i +: 8];
   end
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      st_d    = st_q;
      if (state_q == IDLE && bus.in_valid) begin
         state_d = ROUND;
         round_d = 4'd1;
         st_d    = bus.plaintext ^ keys[0 +: 128];
      end else if (state_q == ROUND) begin
         st_d    = rnd;
         state_d = round_q == 4'(NR) ? DONE : ROUND;
         round_d = round_q == 4'(NR) ? 4'd0 : round_q + 4'd1;
      end else if (state_q == DONE && handoff) state_d = IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         st_q    <= st_d;
      end
`ifdef AES_OUT_REG_EN
   // first DONE cycle copies the final state into the output register
   logic         ov_q, ov_d;
   logic [0:127] ct_q, ct_d;
   always_comb begin
      ov_d = ov_q;
      ct_d = ct_q;
      if (state_q == DONE && !ov_q) begin
         ov_d = 1'b1;
         ct_d = st_q;
      end else if (handoff) begin
         ov_d = 1'b0;
         ct_d = '0;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ov_q <= 1'b0;
         ct_q <= '0;
      end else begin
         ov_q <= ov_d;
         ct_q <= ct_d;
      end
   assign out_valid      = ov_q;
   assign bus.ciphertext = ct_q;
`else
   assign out_valid      = state_q == DONE;
   assign bus.ciphertext = st_q;
`endif
   assign handoff       = out_valid && bus.out_ready;
   assign bus.out_valid = out_valid;
   assign bus.in_ready  = state_q == IDLE;
   assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_aes_cipher_rounds.sv
// tb_aes_cipher_rounds: directed FIPS-197 vectors against a job-level AES model checked every cycle
module tb_aes_cipher_rounds;
`ifdef AES_OUT_REG_EN
   localparam int LAT  = 11;
   localparam bit OREG = 1'b1;
`else
   localparam int LAT  = 10;
   localparam bit OREG = 1'b0;
`endif
   localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   aes_cipher_rounds_if bus ();
   aes_cipher_rounds dut (.clk(clk), .reset(reset), .bus(bus));
   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;
   logic [7:0] sb [256];
   logic m_busy;
   int m_cnt;
   logic [0:127] m_ct;
   logic [0:127] got [$];
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction
   function automatic logic [0:1407] expand(input logic [0:127] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      logic [0:1407] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32 * i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) o[32 * i +: 32] = w[i];
      return o;
   endfunction
   function automatic logic [0:127] aes_model(input logic [0:127] p, input logic [0:1407] k);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [0:127] o;
      for (int i = 0; i < 16; i++) s[i] = p[8 * i +: 8] ^ k[8 * i +: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               t[row + 4 * col] = sb[s[row + 4 * ((col + row) % 4)]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row + 4 * col] = (r == 10) ? t[row + 4 * col] :
                  mul(8'h02, t[row + 4 * col]) ^ mul(8'h03, t[(row + 1) % 4 + 4 * col]) ^
                  t[(row + 2) % 4 + 4 * col] ^ t[(row + 3) % 4 + 4 * col];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[128 * r + 8 * i +: 8];
      end
      for (int i = 0; i < 16; i++) o[8 * i +: 8] = s[i];
      return o;
   endfunction
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_ct   <= '0;
      end else if (!m_busy) begin
         if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_ct   <= aes_model(bus.plaintext, bus.keys);
         end
      end else if (m_cnt == LAT) begin
         if (bus.out_ready) m_busy <= 1'b0;
      end else m_cnt <= m_cnt + 1;
   always @(negedge clk)
      if (chk_en) begin
         if (reset) begin
            chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_busy", 128'(bus.busy), 128'(0));
            chk("rst_ciphertext", bus.ciphertext, 128'(0));
         end else begin
            chk("in_ready", 128'(bus.in_ready), 128'(!m_busy));
            chk("out_valid", 128'(bus.out_valid), 128'(m_busy && m_cnt == LAT));
            chk("busy", 128'(bus.busy), 128'(m_busy));
            if (OREG || (m_busy && m_cnt == LAT))
               chk("ciphertext", bus.ciphertext, (m_busy && m_cnt == LAT) ? m_ct : 128'(0));
         end
      end
   always @(posedge clk)
      if (!reset && bus.out_valid && bus.out_ready) got.push_back(bus.ciphertext);
   task automatic job(input logic [0:127] p, input logic [0:1407] k);
      bus.plaintext = p;
      bus.keys      = k;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask
   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         tests++;
         fails++;
         $display("FAIL %s: out_valid still low after %0d cycles, required within 40", nm, n);
      end
   endtask
   task automatic take(input string nm, input logic [0:127] exp);
      if (got.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no ciphertext handed off, required %h", nm, exp);
      end else chk(nm, got.pop_front(), exp);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      logic [0:1407] kb, kc;
      logic [7:0] inv, aff, cst;
      cst = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            aff[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
         sb[a] = aff;
      end
      kb = expand(KEY_B);
      kc = expand(KEY_C);
      chk("model_sbox_00", 128'(sb[8'h00]), 128'(8'h63));
      chk("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));
      chk("model_rk10_b", kb[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_rk10_c", kc[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("model_ct_b", aes_model(PT_B, kb), CT_B);
      chk("model_ct_c", aes_model(PT_C, kc), CT_C);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.plaintext = '0;
      bus.keys      = '0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
      chk("reset_ciphertext", bus.ciphertext, 128'(0));
      job(PT_B, kb);
      wait_valid("app_b");
      @(posedge clk);
      #1 take("app_b_ct", CT_B);
      bus.out_ready = 1'b0;
      job(PT_C, kc);
      wait_valid("backpressure");
      repeat (20) begin
         @(negedge clk);
         chk("bp_hold_ct", bus.ciphertext, CT_C);
         chk("bp_hold_in_ready", 128'(bus.in_ready), 128'(0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
      chk("bp_release_out_valid", 128'(bus.out_valid), 128'(0));
      take("bp_ct", CT_C);
      job(PT_B, kb);
      repeat (3) @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.plaintext = PT_C;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid("busy_input");
      @(posedge clk);
      #1 take("busy_input_ct", CT_B);
      chk("busy_input_single_output", 128'(got.size()), 128'(0));
      job(PT_B, kb);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("midrst_no_output", 128'(got.size()), 128'(0));
      job(PT_C, kc);
      wait_valid("after_reset");
      @(posedge clk);
      #1 take("after_reset_ct", CT_C);
      bus.plaintext = PT_B;
      bus.keys      = kb;
      bus.in_valid  = 1'b1;
      wait_valid("b2b_first");
      bus.plaintext = PT_C;
      bus.keys      = kc;
      @(posedge clk);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid("b2b_second");
      @(posedge clk);
      #1 take("b2b_ct_first", CT_B);
      take("b2b_ct_second", CT_C);
      repeat (3) @(negedge clk);
      chk("no_extra_outputs", 128'(got.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
